bram_unaligned_rw: RTL and testbench

- Parametrised successor to the unaligned block RAM: byte-addressed single-bank synchronous RAM.
- Supports 1/2/4-byte (up to DATA_BYTES) reads and writes at any byte alignment.
- Uses a valid/ready request port and a registered response port.
- An access spanning two words runs as two RAM cycles under an internal FSM.
- Sits between the core load/store unit and on-chip memory.

---
 rtl/bram_unaligned_rw_if.sv | 26 ++
 rtl/bram_unaligned_rw.sv | 176 +++++++++++++++++
 tb/tb_bram_unaligned_rw.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_unaligned_rw_if.sv
// Request/response bus of the unaligned block RAM.
// The master issues byte-addressed requests on a valid/ready handshake.
// The slave answers each accepted request with a one-cycle rsp_valid pulse.
interface bram_unaligned_rw_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 11
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_W-1:0]       req_addr;
   logic [1:0]              req_size;
   logic [8*DATA_BYTES-1:0] req_wdata;
   logic                    rsp_valid;
   logic [8*DATA_BYTES-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/bram_unaligned_rw.sv
// Byte-addressed single-bank synchronous RAM with unaligned 1..DATA_BYTES
// byte reads and writes. An access that straddles two words takes a second
// RAM cycle (state SECOND); otherwise the response follows one cycle after
// acceptance. Addresses wrap modulo the memory size.
module bram_unaligned_rw #(
   parameter int DATA_BYTES  = 4,
   parameter int DEPTH_WORDS = 512,
   parameter int ADDR_W      = 11
) (
   input  logic             clock,
   input  logic             reset_n,
   bram_unaligned_rw_if.slave bus
);
   localparam int DW     = 8 * DATA_BYTES;
   localparam int LW     = $clog2(DATA_BYTES);
   localparam int WORD_W = ADDR_W - LW;
   localparam logic [1:0] MAX_SIZE = 2'(LW);

   typedef enum logic [0:0] {IDLE, SECOND} state_t;

   state_t state_reg;
   state_t state_next;

   // Request decode
   logic [LW-1:0]         req_off;
   logic [WORD_W-1:0]     req_word;
   logic [1:0]            size_clamped;
   logic [LW:0]           nbytes;
   logic [2*DATA_BYTES-1:0] len_mask;
   logic [2*DATA_BYTES-1:0] be_full;
   logic [2*DW-1:0]       data_full;
   logic [LW+1:0]         span_end;
   logic                  crossing;
   logic                  accept;

   // Memory port
   logic [DW-1:0]         mem [DEPTH_WORDS];
   logic                  mem_en;
   logic                  mem_we;
   logic [DATA_BYTES-1:0] mem_be;
   logic [WORD_W-1:0]     mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic [DW-1:0]         rd_word_reg;
   logic [DW-1:0]         lo_word_reg;

   // Control and response state
   logic                  ready_reg;
   logic                  rsp_valid_reg;
   logic                  rsp_read_reg;
   logic                  rsp_cross_reg;
   logic [LW-1:0]         rsp_off_reg;
   logic [DATA_BYTES-1:0] rsp_mask_reg;
   logic                  write_reg;
   logic [WORD_W-1:0]     word_hi_reg;
   logic [DATA_BYTES-1:0] be_hi_reg;
   logic [DW-1:0]         wdata_hi_reg;
   logic [DW-1:0]         hold_reg;

   // Read alignment
   logic [2*DW-1:0]       combined;
   logic [2*DW-1:0]       shifted;
   logic [DW-1:0]         aligned;

   assign req_off      = bus.req_addr[LW-1:0];
   assign req_word     = bus.req_addr[ADDR_W-1:LW];
   assign size_clamped = (bus.req_size > MAX_SIZE) ? MAX_SIZE : bus.req_size;
   assign nbytes       = (LW+1)'(1) << size_clamped;
   // Byte enables and data laid out across two adjacent words; the low half
   // is the first access, the high half is what spills into the next word.
   assign len_mask     = ((2*DATA_BYTES)'(1) << nbytes) - (2*DATA_BYTES)'(1);
   assign be_full      = len_mask << req_off;
   assign data_full    = {{DW{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
   assign span_end     = (LW+2)'(req_off) + (LW+2)'(nbytes);
   assign crossing     = span_end > (LW+2)'(DATA_BYTES);
   assign accept       = bus.req_valid && ready_reg;

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next state and RAM port control
   always_comb begin
      state_next = state_reg;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_addr   = req_word;
      mem_wdata  = data_full[DW-1:0];
      case (state_reg)
         IDLE: begin
            if (accept) begin
               mem_en = 1'b1;
               mem_we = bus.req_write;
               mem_be = be_full[DATA_BYTES-1:0];
               if (crossing) state_next = SECOND;
            end
         end
         SECOND: begin
            mem_en     = 1'b1;
            mem_we     = write_reg;
            mem_be     = be_hi_reg;
            mem_addr   = word_hi_reg;
            mem_wdata  = wdata_hi_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // RAM array: byte-enabled write, registered read; contents are never reset
   always_ff @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
               if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end else begin
            rd_word_reg <= mem[mem_addr];
         end
      end
   end

   // Keep the first word of a crossing read while the second word is fetched
   always_ff @(posedge clock) begin
      if (state_reg == SECOND) lo_word_reg <= rd_word_reg;
   end

   // Handshake, per-request context and response bookkeeping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_read_reg  <= 1'b0;
         rsp_cross_reg <= 1'b0;
         rsp_off_reg   <= '0;
         rsp_mask_reg  <= '0;
         write_reg     <= 1'b0;
         word_hi_reg   <= '0;
         be_hi_reg     <= '0;
         wdata_hi_reg  <= '0;
         hold_reg      <= '0;
      end else begin
         ready_reg     <= (state_next == IDLE);
         rsp_valid_reg <= (accept && !crossing) || (state_reg == SECOND);
         if (accept) begin
            rsp_read_reg  <= !bus.req_write;
            rsp_cross_reg <= crossing;
            rsp_off_reg   <= req_off;
            rsp_mask_reg  <= len_mask[DATA_BYTES-1:0];
            write_reg     <= bus.req_write;
            word_hi_reg   <= req_word + WORD_W'(1);
            be_hi_reg     <= be_full[2*DATA_BYTES-1:DATA_BYTES];
            wdata_hi_reg  <= data_full[2*DW-1:DW];
         end
         if (rsp_valid_reg && rsp_read_reg) hold_reg <= aligned;
      end
   end

   // Merge (for crossing reads) and right-align the fetched bytes
   assign combined = rsp_cross_reg ? {rd_word_reg, lo_word_reg}
                                   : {{DW{1'b0}}, rd_word_reg};
   assign shifted  = combined >> {rsp_off_reg, 3'b000};

   generate
      for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
         assign aligned[8*gi +: 8] = shifted[8*gi +: 8] & {8{rsp_mask_reg[gi]}};
      end
   endgenerate

   assign bus.req_ready = ready_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   // A fresh read result is shown during its pulse, then held until replaced
   assign bus.rsp_rdata = (rsp_valid_reg && rsp_read_reg) ? aligned : hold_reg;
endmodule

// File: tb/tb_bram_unaligned_rw.sv
// Directed bench for bram_unaligned_rw with DATA_BYTES=4, DEPTH_WORDS=512.
module tb_bram_unaligned_rw;
   logic clock;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   bram_unaligned_rw_if #(.DATA_BYTES(4), .ADDR_W(11)) bus ();

   bram_unaligned_rw #(
      .DATA_BYTES(4), .DEPTH_WORDS(512), .ADDR_W(11)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Issue one request and wait for its response.
   task automatic do_req(input logic wr, input logic [10:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output int rdy_low);
      int waitc;
      lat = 0;
      rd = '0;
      rdy_low = 0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_size  = size;
      bus.req_wdata = wd;
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      if (!bus.req_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_timeout addr=%0d: req_ready=%0b, required 1", addr, bus.req_ready);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (!bus.req_ready) rdy_low++;
         if (bus.rsp_valid) begin
            lat = c;
            rd = bus.rsp_rdata;
            break;
         end
         @(posedge clock);
         #1;
      end
      $display("[TB] req wr=%0b addr=%0d size=%0d wdata=%h -> latency=%0d rdata=%h ready_low=%0d",
               wr, addr, size, wd, lat, rd, rdy_low);
   endtask

   task automatic test_reset();
      tests_run++;
      if (bus.req_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ready: got %0b, required 0", bus.req_ready);
      end
      tests_run++;
      if (bus.rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_rsp_valid: got %0b, required 0", bus.rsp_valid);
      end
      tests_run++;
      if (bus.rsp_rdata !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_rdata: got %h, required 00000000", bus.rsp_rdata);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      tests_run++;
      if (bus.req_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ready_after_reset: got %0b, required 1", bus.req_ready);
      end
   endtask

   task automatic test_aligned();
      int lat, rl;
      logic [31:0] rd;
      do_req(1'b1, 11'd0, 2'd2, 32'h12345678, lat, rd, rl);
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("[TB] FAIL aligned_write_latency: got %0d, required 1", lat);
      end
      do_req(1'b0, 11'd0, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("[TB] FAIL aligned_read_latency: got %0d, required 1", lat);
      end
      tests_run++;
      if (rd !== 32'h12345678) begin
         tests_failed++;
         $display("[TB] FAIL aligned_read_data: got %h, required 12345678", rd);
      end
   endtask

   task automatic clear_words12();
      int lat, rl;
      logic [31:0] rd;
      do_req(1'b1, 11'd4, 2'd2, 32'h0, lat, rd, rl);
      do_req(1'b1, 11'd8, 2'd2, 32'h0, lat, rd, rl);
   endtask

   task automatic test_crossing();
      int lat, rl;
      logic [31:0] rd;
      do_req(1'b1, 11'd3, 2'd2, 32'hAABBCCDD, lat, rd, rl);
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("[TB] FAIL cross_write_latency: got %0d, required 2", lat);
      end
      tests_run++;
      if (rl !== 1) begin
         tests_failed++;
         $display("[TB] FAIL cross_ready_low: got %0d cycles, required 1", rl);
      end
      tests_run++;
      if (rd !== 32'h12345678) begin
         tests_failed++;
         $display("[TB] FAIL write_keeps_rdata: got %h, required 12345678", rd);
      end
      do_req(1'b0, 11'd0, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'hDD345678) begin
         tests_failed++;
         $display("[TB] FAIL cross_read_w0: got %h, required DD345678", rd);
      end
      do_req(1'b0, 11'd4, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h00AABBCC) begin
         tests_failed++;
         $display("[TB] FAIL cross_read_w1: got %h, required 00AABBCC", rd);
      end
      do_req(1'b0, 11'd3, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'hAABBCCDD) begin
         tests_failed++;
         $display("[TB] FAIL cross_read_a3: got %h, required AABBCCDD", rd);
      end
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("[TB] FAIL cross_read_latency: got %0d, required 2", lat);
      end
   endtask

   task automatic test_subword();
      int lat, rl;
      logic [31:0] rd;
      do_req(1'b0, 11'd5, 2'd0, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h000000BB) begin
         tests_failed++;
         $display("[TB] FAIL byte_read_a5: got %h, required 000000BB", rd);
      end
      do_req(1'b0, 11'd1, 2'd1, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h00003456) begin
         tests_failed++;
         $display("[TB] FAIL half_read_a1: got %h, required 00003456", rd);
      end
      do_req(1'b0, 11'd0, 2'd3, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'hDD345678) begin
         tests_failed++;
         $display("[TB] FAIL clamped_read_a0: got %h, required DD345678", rd);
      end
   endtask

   task automatic test_wrap();
      int lat, rl;
      logic [31:0] rd;
      do_req(1'b1, 11'd2047, 2'd1, 32'h0000BEEF, lat, rd, rl);
      tests_run++;
      if (lat !== 2) begin
         tests_failed++;
         $display("[TB] FAIL wrap_write_latency: got %0d, required 2", lat);
      end
      do_req(1'b0, 11'd0, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'hDD3456BE) begin
         tests_failed++;
         $display("[TB] FAIL wrap_read_w0: got %h, required DD3456BE", rd);
      end
      do_req(1'b0, 11'd2047, 2'd1, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h0000BEEF) begin
         tests_failed++;
         $display("[TB] FAIL wrap_read_half: got %h, required 0000BEEF", rd);
      end
   endtask

   task automatic test_reset_mid_crossing();
      int lat, rl;
      int rsp_seen;
      logic [31:0] rd;
      rsp_seen = 0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 11'd6;
      bus.req_size  = 2'd2;
      bus.req_wdata = 32'h11223344;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      // Now in the SECOND cycle: pull reset before its edge
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (bus.req_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midreset_ready: got %0b, required 0", bus.req_ready);
      end
      for (int c = 0; c < 3; c++) begin
         if (bus.rsp_valid) rsp_seen++;
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      if (bus.rsp_valid) rsp_seen++;
      tests_run++;
      if (bus.req_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midreset_ready_after: got %0b, required 1", bus.req_ready);
      end
      tests_run++;
      if (rsp_seen !== 0) begin
         tests_failed++;
         $display("[TB] FAIL midreset_no_rsp: got %0d pulses, required 0", rsp_seen);
      end
      $display("[TB] req wr=1 addr=6 size=2 wdata=11223344 interrupted by reset, rsp pulses=%0d", rsp_seen);
      do_req(1'b0, 11'd4, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h33440000) begin
         tests_failed++;
         $display("[TB] FAIL midreset_read_w1: got %h, required 33440000", rd);
      end
      do_req(1'b0, 11'd8, 2'd2, 32'h0, lat, rd, rl);
      tests_run++;
      if (rd !== 32'h00000000) begin
         tests_failed++;
         $display("[TB] FAIL midreset_read_w2: got %h, required 00000000", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic v1, v2, v3;
      logic [31:0] rd;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 11'd16;
      bus.req_size  = 2'd2;
      bus.req_wdata = 32'hCAFEF00D;
      @(posedge clock);
      #1;
      v1 = bus.rsp_valid;
      bus.req_write = 1'b0;
      bus.req_wdata = 32'h0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      v2 = bus.rsp_valid;
      rd = bus.rsp_rdata;
      @(posedge clock);
      #1;
      v3 = bus.rsp_valid;
      $display("[TB] b2b write/read addr=16 -> rsp_valid=%0b,%0b,%0b rdata=%h", v1, v2, v3, rd);
      tests_run++;
      if (v1 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_write_ack: got %0b, required 1", v1);
      end
      tests_run++;
      if (v2 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_read_rsp: got %0b, required 1", v2);
      end
      tests_run++;
      if (rd !== 32'hCAFEF00D) begin
         tests_failed++;
         $display("[TB] FAIL b2b_read_data: got %h, required CAFEF00D", rd);
      end
      tests_run++;
      if (v3 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_idle_after: got %0b, required 0", v3);
      end
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_size  = '0;
      bus.req_wdata = '0;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      test_aligned();
      clear_words12();
      test_crossing();
      test_subword();
      test_wrap();
      clear_words12();
      test_reset_mid_crossing();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
